// File: rtl/icetap_pkg.sv
// icetap_pkg: shared FSM state encoding and stream byte-count derivations for the icetap readout path
package icetap_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_HDR, ST_RD, ST_WT, ST_SH} state_t;
  localparam int HDR_FIELDS = 2;
  function automatic int bytes_for(input int bits);
    return (bits + 7) / 8;
  endfunction
  function automatic int hdr_bytes(input int addr_bits);
    return bytes_for(addr_bits);
  endfunction
  function automatic int data_bytes(input int nr_signals);
    return bytes_for(nr_signals);
  endfunction
  function automatic int max_int(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/icetap_readout_seq_if.sv
// icetap_readout_seq_if: RAM read port (mem_rd_*) and byte stream (out_*) between sequencer (master) and RAM/sink (slave)
interface icetap_readout_seq_if #(
  parameter int NR_SIGNALS = 16,
  parameter int ADDR_BITS = 8
);
  logic                  mem_rd_ena;
  logic [ADDR_BITS-1:0]  mem_rd_addr;
  logic [NR_SIGNALS-1:0] mem_rd_data;
  logic                  out_valid;
  logic [7:0]            out_data;
  logic                  out_last;
  logic                  out_ready;
  modport master (
    output mem_rd_ena, mem_rd_addr, out_valid, out_data, out_last,
    input  mem_rd_data, out_ready
  );
  modport slave (
    input  mem_rd_ena, mem_rd_addr, out_valid, out_data, out_last,
    output mem_rd_data, out_ready
  );
endinterface

// File: rtl/icetap_byte_shifter.sv
// icetap_byte_shifter: loads a word (i_word, i_last_idx = byte count - 1) and emits it LSB byte first on o_valid/o_data/i_ready, o_last on its final byte; i_clr drops it mid-word
module icetap_byte_shifter #(
  parameter int BYTES = 2,
  localparam int CW = $clog2(BYTES) + 1
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clr,
  input  logic               i_load,
  input  logic [BYTES*8-1:0] i_word,
  input  logic [CW-1:0]      i_last_idx,
  input  logic               i_ready,
  output logic               o_valid,
  output logic               o_last,
  output logic [7:0]         o_data
);
  logic [BYTES*8-1:0] r_word;
  logic [CW-1:0]      r_idx;
  logic               r_valid;
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_valid <= 1'b0;
      r_word  <= '0;
      r_idx   <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_word  <= i_word;
      r_idx   <= i_last_idx;
    end else if (r_valid && i_ready) begin
      r_valid <= r_idx != '0;
      r_word  <= r_word >> 8;
      r_idx   <= r_idx - CW'(1);
    end
  end
  assign o_valid = r_valid;
  assign o_last  = r_valid && r_idx == '0;
  assign o_data  = r_valid ? r_word[7:0] : 8'h00;
endmodule

// File: rtl/icetap_readout_seq.sv
// icetap_readout_seq: walks the capture RAM start..stop (go/abort/capture_done, *_addr in; busy/done out) and streams header + samples as bytes over bus
module icetap_readout_seq
  import icetap_pkg::*;
#(
  parameter int NR_SIGNALS = 16,
  parameter int RECORD_DEPTH = 256,
  localparam int ADDR_BITS = $clog2(RECORD_DEPTH)
)(
  input  logic                 scan_clk,
  input  logic                 scan_reset,
  input  logic                 go,
  input  logic                 abort,
  input  logic                 capture_done,
  input  logic [ADDR_BITS-1:0] start_addr,
  input  logic [ADDR_BITS-1:0] trigger_addr,
  input  logic [ADDR_BITS-1:0] stop_addr,
  icetap_readout_seq_if.master bus,
  output logic                 busy,
  output logic                 done
);
  localparam int DATA_BYTES = data_bytes(NR_SIGNALS);
  localparam int HDR_BYTES = hdr_bytes(ADDR_BITS);
  localparam int SW = max_int(HDR_FIELDS * HDR_BYTES, DATA_BYTES);
  localparam int CW = $clog2(SW) + 1;
  localparam logic [CW-1:0] HDR_IDX = CW'(HDR_FIELDS * HDR_BYTES - 1);
  localparam logic [CW-1:0] DATA_IDX = CW'(DATA_BYTES - 1);
  state_t               r_state, w_next;
  logic [ADDR_BITS-1:0] r_addr;
  logic [ADDR_BITS:0]   r_left;
  logic                 r_done;
  logic [ADDR_BITS-1:0] w_span, w_off;
  logic [ADDR_BITS:0]   w_n;
  logic [SW*8-1:0]      w_hdr_word, w_data_word, w_word;
  logic [CW-1:0]        w_last_idx;
  logic                 w_accept, w_adv, w_done, w_load, w_sh_last, w_byte_end, w_final;
  assign w_span      = stop_addr - start_addr;
  assign w_off       = trigger_addr - start_addr;
  assign w_n         = {1'b0, w_span} + (ADDR_BITS+1)'(1);
  // header word is sent LSB first: count-1 field, then trigger offset field
  assign w_hdr_word  = (SW*8)'({(HDR_BYTES*8)'(w_off), (HDR_BYTES*8)'(w_span)});
  assign w_data_word = (SW*8)'(bus.mem_rd_data);
  assign w_byte_end  = bus.out_valid && bus.out_ready && w_sh_last;
  assign w_final     = r_left == (ADDR_BITS+1)'(1);
  always_ff @(posedge scan_clk) begin
    if (scan_reset) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_left  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_done;
      if (w_accept) begin
        r_addr <= start_addr;
        r_left <= w_n;
      end else if (w_adv) begin
        r_addr <= r_addr + ADDR_BITS'(1);
        r_left <= r_left - (ADDR_BITS+1)'(1);
      end
    end
  end
  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_adv      = 1'b0;
    w_done     = 1'b0;
    w_load     = 1'b0;
    w_word     = w_hdr_word;
    w_last_idx = HDR_IDX;
    if (abort) begin
      w_next = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: if (go && capture_done && !r_done) begin
          w_next   = ST_HDR;
          w_accept = 1'b1;
          w_load   = 1'b1;
        end
        ST_HDR: w_next = w_byte_end ? ST_RD : ST_HDR;
        ST_RD: w_next = ST_WT;
        ST_WT: begin
          w_next     = ST_SH;
          w_load     = 1'b1;
          w_word     = w_data_word;
          w_last_idx = DATA_IDX;
        end
        ST_SH: if (w_byte_end) begin
          w_done = w_final;
          w_adv  = !w_final;
          w_next = w_final ? ST_IDLE : ST_RD;
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end
  icetap_byte_shifter #(.BYTES(SW)) u_shift (
    .clk        (scan_clk),
    .rst        (scan_reset),
    .i_clr      (abort),
    .i_load     (w_load),
    .i_word     (w_word),
    .i_last_idx (w_last_idx),
    .i_ready    (bus.out_ready),
    .o_valid    (bus.out_valid),
    .o_last     (w_sh_last),
    .o_data     (bus.out_data)
  );
  assign bus.out_last    = w_sh_last && r_state == ST_SH && w_final;
  assign bus.mem_rd_ena  = r_state == ST_RD;
  assign bus.mem_rd_addr = r_addr;
  assign busy            = r_state != ST_IDLE;
  assign done            = r_done;
endmodule
